// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty flags,
// synchronous flush and sticky overflow/underflow error flags.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_LEVEL   = 3,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_C     = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_C     = AE_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ZERO_C   = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] ONE_C    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DZERO_C = {DATA_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic full_s;
  logic empty_s;
  logic wr_acc_s;
  logic rd_acc_s;

  // Flags come only from the registered count, so a same-cycle pop never frees a slot
  assign full_s   = (count_q == DEPTH_C);
  assign empty_s  = (count_q == ZERO_C);
  assign wr_acc_s = wr_en & ~full_s & ~flush;
  assign rd_acc_s = rd_en & ~empty_s & ~flush;

  // Next-state for pointers, count, read port and sticky errors
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wptr_d      = ZERO_C;
      rptr_d      = ZERO_C;
      count_d     = ZERO_C;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc_s) begin
        wptr_d = wptr_q + ONE_C;
      end else begin
        wptr_d = wptr_q;
      end
      if (rd_acc_s) begin
        rptr_d     = rptr_q + ONE_C;
        rd_data_d  = mem_q[rptr_q[ADDR_WIDTH-1:0]];
        rd_valid_d = 1'b1;
      end else begin
        rptr_d     = rptr_q;
        rd_valid_d = 1'b0;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
      if (wr_en && full_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
      if (rd_en && empty_s) begin
        underflow_d = 1'b1;
      end else begin
        underflow_d = underflow_q;
      end
    end
  end

  // Control and read-port state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q      <= ZERO_C;
      rptr_q      <= ZERO_C;
      count_q     <= ZERO_C;
      rd_data_q   <= DZERO_C;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents are don't-care after reset so it carries no reset
  always_ff @(posedge clock) begin
    if (wr_acc_s) begin
      mem_q[wptr_q[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
